// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR register pair plus a four-state memory access
// sequencer (IDLE -> SETUP -> WAIT -> DONE) with a fixed number of wait states.
// Optional feature macro: MEM_ACCESS_READY_EN adds a mem_ready_i handshake
// that holds the sequencer in WAIT until the memory signals ready.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] bus_data_i,
  input  logic        ld_mar_i,
  input  logic        ld_mdr_i,
  input  logic        mio_en_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [15:0] mem_rdata_i,
`ifdef MEM_ACCESS_READY_EN
  input  logic        mem_ready_i,
`endif
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [15:0] mar_o,
  output logic [15:0] mdr_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_DONE
  } state_e;

  // The counter holds the number of WAIT cycles still to come after the
  // current one, so WAIT exits when it reads zero.
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;

  // Next-state logic: register loads only in IDLE, sequencing through the access,
  // and read-data capture on the way out of DONE.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld_mar_i) mar_d = bus_data_i;
        if (ld_mdr_i) mdr_d = mio_en_i ? mem_rdata_i : bus_data_i;
        if (mem_req_i) begin
          op_d    = mem_we_i;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d = CNT_LOAD;
`ifdef MEM_ACCESS_READY_EN
        state_d = S_WAIT;
`else
        state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
`endif
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
`ifdef MEM_ACCESS_READY_EN
        else if (mem_ready_i) begin
          state_d = S_DONE;
        end
`else
        else begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (!op_q) mdr_d = mem_rdata_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset overrides every load and request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      op_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mem_rd_o    = busy_o & ~op_q;
  assign mem_wr_o    = busy_o & op_q;
  assign mar_o       = mar_q;
  assign mdr_o       = mdr_q;
  assign mem_addr_o  = mar_q;
  assign mem_wdata_o = mdr_q;

endmodule
